// File: rtl/apb_slv_pkg.sv
// apb_slv_pkg: shared types and helpers for the APB slave memory model.
//   state_e  - transfer FSM states (IDLE, ACCESS)
//   wcnt_t   - 8-bit wait-state counter
//   lsb_of() - number of byte-offset address bits for a given data width
package apb_slv_pkg;

  typedef enum logic {IDLE, ACCESS} state_e;

  typedef logic [7:0] wcnt_t;

  // Byte-offset bits below the word index: log2(DW/8).
  function automatic int unsigned lsb_of(input int unsigned dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/apb_slave_mem_model_if.sv
// apb_slave_mem_model_if: APB bus between a master and the memory-model slave.
//   psel/penable/pwrite/paddr/pwdata  master -> slave
//   pstrb                             master -> slave (only with APB_SLV_PSTRB_EN)
//   prdata/pready/pslverr             slave -> master
interface apb_slave_mem_model_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
`ifdef APB_SLV_PSTRB_EN
  logic [DW/8-1:0] pstrb;
`endif
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  modport master (
`ifdef APB_SLV_PSTRB_EN
    output pstrb,
`endif
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
`ifdef APB_SLV_PSTRB_EN
    input  pstrb,
`endif
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slv_mem_array.sv
// apb_slv_mem_array: DEPTH x DW flop array, async reset to RESET_VALUE.
//   clk_i, rst_ni          clock, async active-low reset
//   we_i, waddr_i, wdata_i write port; wbe_i selects byte lanes
//   raddr_i, rdata_o       combinational read port
module apb_slv_mem_array #(
  parameter int            DW          = 32,
  parameter int            DEPTH       = 64,
  parameter int            IDXW        = $clog2(DEPTH),
  parameter logic [DW-1:0] RESET_VALUE = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [IDXW-1:0] waddr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW/8-1:0] wbe_i,
  input  logic [IDXW-1:0] raddr_i,
  output logic [DW-1:0]   rdata_o
);
  localparam int NB = DW / 8;

  logic [DEPTH-1:0][DW-1:0] mem_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int w = 0; w < DEPTH; w++) mem_q[w] <= RESET_VALUE;
    end else if (we_i) begin
      for (int b = 0; b < NB; b++)
        if (wbe_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/apb_slave_mem_model.sv
// apb_slave_mem_model: APB slave backed by a flop register array.
//   apb_clk      APB clock
//   sys_aresetn  async active-low reset
//   apb          slave modport: psel, penable, pwrite, paddr, pwdata,
//                [pstrb], prdata, pready, pslverr
// Programmable wait states, byte addressing, pslverr on out-of-range
// accesses and on an access phase without a preceding setup phase.
// Optional: define APB_SLV_PSTRB_EN for byte-strobed writes via pstrb.
module apb_slave_mem_model
  import apb_slv_pkg::*;
#(
  parameter int                AW_APB      = 32,
  parameter int                DW_APB      = 32,
  parameter int                DEPTH       = 64,
  parameter int                WAIT_STATES = 1,
  parameter logic [DW_APB-1:0] RESET_VALUE = '0
) (
  input logic                   apb_clk,
  input logic                   sys_aresetn,
  apb_slave_mem_model_if.slave  apb
);
  localparam int LSB  = lsb_of(DW_APB);
  localparam int IDXW = $clog2(DEPTH);

  state_e             state_q, state_d;
  wcnt_t              cnt_q, cnt_d;
  logic               ready, err, done;
  logic               in_range, we;
  logic [IDXW-1:0]    idx;
  logic [DW_APB/8-1:0] wbe;
  logic [DW_APB-1:0]  rdata;

  // Range check spans the full address so high-bit aliases are rejected.
  assign in_range = (apb.paddr >> LSB) < AW_APB'(DEPTH);
  assign idx      = apb.paddr[LSB +: IDXW];

  always_ff @(posedge apb_clk or negedge sys_aresetn) begin
    if (!sys_aresetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    err     = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (apb.psel && !apb.penable) begin
          state_d = ACCESS;
          cnt_d   = wcnt_t'(WAIT_STATES);
        end else if (apb.psel && apb.penable) begin
          // Access phase with no setup: reject immediately, stay idle.
          ready = 1'b1;
          err   = 1'b1;
        end
      end
      ACCESS: begin
        if (!apb.psel) begin
          state_d = IDLE;  // master aborted; nothing committed
        end else if (apb.penable) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            ready   = 1'b1;
            err     = !in_range;
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign we = done && apb.pwrite && in_range;

`ifdef APB_SLV_PSTRB_EN
  assign wbe = apb.pstrb;
`else
  assign wbe = '1;
`endif

  apb_slv_mem_array #(
    .DW          (DW_APB),
    .DEPTH       (DEPTH),
    .IDXW        (IDXW),
    .RESET_VALUE (RESET_VALUE)
  ) u_mem (
    .clk_i   (apb_clk),
    .rst_ni  (sys_aresetn),
    .we_i    (we),
    .waddr_i (idx),
    .wdata_i (apb.pwdata),
    .wbe_i   (wbe),
    .raddr_i (idx),
    .rdata_o (rdata)
  );

  // Outputs are gated by reset so they drop the instant reset asserts,
  // even while the master still holds psel/penable.
  assign apb.pready  = ready && sys_aresetn;
  assign apb.pslverr = err && sys_aresetn;
  assign apb.prdata  = (done && !apb.pwrite && in_range && sys_aresetn) ? rdata : '0;
endmodule

// File: tb/tb_apb_slave_mem_model.sv
// tb_apb_slave_mem_model: directed bench for apb_slave_mem_model.
// Three instances share clock and reset: [0] WAIT_STATES=1, [1] 0, [2] 3;
// all DW=32, DEPTH=64, RESET_VALUE=RV.
module tb_apb_slave_mem_model;
  localparam logic [31:0] RV = 32'h5A5A_0F0F;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        psel_v    [3];
  logic        penable_v [3];
  logic        pwrite_v  [3];
  logic [31:0] paddr_v   [3];
  logic [31:0] pwdata_v  [3];
  logic [3:0]  pstrb_v   [3];
  logic [31:0] prdata_v  [3];
  logic        pready_v  [3];
  logic        pslverr_v [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 1 : (g == 1) ? 0 : 3;
    apb_slave_mem_model_if #(.AW(32), .DW(32)) bus ();
    assign bus.psel    = psel_v[g];
    assign bus.penable = penable_v[g];
    assign bus.pwrite  = pwrite_v[g];
    assign bus.paddr   = paddr_v[g];
    assign bus.pwdata  = pwdata_v[g];
`ifdef APB_SLV_PSTRB_EN
    assign bus.pstrb   = pstrb_v[g];
`endif
    assign prdata_v[g]  = bus.prdata;
    assign pready_v[g]  = bus.pready;
    assign pslverr_v[g] = bus.pslverr;

    apb_slave_mem_model #(
      .AW_APB(32), .DW_APB(32), .DEPTH(64), .WAIT_STATES(WS), .RESET_VALUE(RV)
    ) u_dut (
      .apb_clk     (clk),
      .sys_aresetn (rst_n),
      .apb         (bus)
    );
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // One transfer on instance k; leaves the bus in the completing cycle so
  // the next xfer can follow back-to-back. Call idle() to release the bus.
  task automatic xfer(input int k, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] strb,
                      input int exp_cyc, input logic exp_err,
                      input logic [31:0] exp_rd, input string tag);
    int cyc;
    bit fin;
    @(posedge clk); #1;
    psel_v[k] = 1'b1; penable_v[k] = 1'b0; pwrite_v[k] = wr;
    paddr_v[k] = a; pwdata_v[k] = d; pstrb_v[k] = strb;
    cyc = 1; fin = 1'b0;
    while (!fin && cyc <= 20) begin
      @(negedge clk);
      if (pready_v[k]) fin = 1'b1;
      else begin
        @(posedge clk); #1;
        penable_v[k] = 1'b1;
        cyc++;
      end
    end
    chk({tag, ".cycle"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, ".pslverr"}, {63'd0, pslverr_v[k]}, {63'd0, exp_err});
    chk({tag, ".prdata"}, {32'd0, prdata_v[k]}, {32'd0, exp_rd});
  endtask

  task automatic idle(input int k);
    @(posedge clk); #1;
    psel_v[k] = 1'b0; penable_v[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      psel_v[k] = 1'b0; penable_v[k] = 1'b0; pwrite_v[k] = 1'b0;
      paddr_v[k] = '0; pwdata_v[k] = '0; pstrb_v[k] = 4'hF;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset.pready",  {63'd0, pready_v[0]},  64'd0);
    chk("reset.pslverr", {63'd0, pslverr_v[0]}, 64'd0);
    chk("reset.prdata",  {32'd0, prdata_v[0]},  64'd0);

    // Latency vs. wait states: read of reset content
    xfer(1, 1'b0, 32'h0, 32'h0, 4'hF, 2, 1'b0, RV, "ws0.rd0"); idle(1);
    xfer(2, 1'b0, 32'h0, 32'h0, 4'hF, 5, 1'b0, RV, "ws3.rd0"); idle(2);
    xfer(1, 1'b1, 32'h8, 32'h0102_0304, 4'hF, 2, 1'b0, 32'h0, "ws0.wr8");
    xfer(1, 1'b0, 32'h8, 32'h0, 4'hF, 2, 1'b0, 32'h0102_0304, "ws0.rd8"); idle(1);

    // Write then back-to-back read, WAIT_STATES=1
    xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3, 1'b0, 32'h0, "wr10");
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 3, 1'b0, 32'hDEAD_BEEF, "rd10"); idle(0);
    // Byte-offset bits ignored
    xfer(0, 1'b0, 32'h13, 32'h0, 4'hF, 3, 1'b0, 32'hDEAD_BEEF, "rd13"); idle(0);
    // Last word
    xfer(0, 1'b1, 32'hFC, 32'h1357_9BDF, 4'hF, 3, 1'b0, 32'h0, "wrFC");
    xfer(0, 1'b0, 32'hFC, 32'h0, 4'hF, 3, 1'b0, 32'h1357_9BDF, "rdFC"); idle(0);

    // Out of range: 0x100 aliases word 0, 0x80000010 aliases word 4
    xfer(0, 1'b1, 32'h100, 32'hCAFE_F00D, 4'hF, 3, 1'b1, 32'h0, "oor.wr100"); idle(0);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, 3, 1'b0, RV, "oor.rd0"); idle(0);
    xfer(0, 1'b1, 32'h8000_0010, 32'h0, 4'hF, 3, 1'b1, 32'h0, "oor.wrhi"); idle(0);
    xfer(0, 1'b0, 32'h8000_0010, 32'h0, 4'hF, 3, 1'b1, 32'h0, "oor.rdhi"); idle(0);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 3, 1'b0, 32'hDEAD_BEEF, "oor.rd10"); idle(0);

    // Protocol violation: access phase without setup
    @(posedge clk); #1;
    psel_v[0] = 1'b1; penable_v[0] = 1'b1; pwrite_v[0] = 1'b1;
    paddr_v[0] = 32'h10; pwdata_v[0] = 32'h0;
    @(negedge clk);
    chk("viol.pready",  {63'd0, pready_v[0]},  64'd1);
    chk("viol.pslverr", {63'd0, pslverr_v[0]}, 64'd1);
    chk("viol.prdata",  {32'd0, prdata_v[0]},  64'd0);
    idle(0);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 3, 1'b0, 32'hDEAD_BEEF, "viol.rd10"); idle(0);

    // Abort: psel dropped in the would-be completing cycle
    @(posedge clk); #1;
    psel_v[0] = 1'b1; penable_v[0] = 1'b0; pwrite_v[0] = 1'b1;
    paddr_v[0] = 32'h14; pwdata_v[0] = 32'h1234_5678;
    @(posedge clk); #1; penable_v[0] = 1'b1;
    @(negedge clk);
    chk("abort.wait.pready", {63'd0, pready_v[0]}, 64'd0);
    @(posedge clk); #1; psel_v[0] = 1'b0; penable_v[0] = 1'b0;
    @(negedge clk);
    chk("abort.pready", {63'd0, pready_v[0]}, 64'd0);
    xfer(0, 1'b0, 32'h14, 32'h0, 4'hF, 3, 1'b0, RV, "abort.rd14"); idle(0);

`ifdef APB_SLV_PSTRB_EN
    xfer(0, 1'b1, 32'h30, 32'h1122_3344, 4'hF, 3, 1'b0, 32'h0, "strb.wrfull"); idle(0);
    xfer(0, 1'b1, 32'h30, 32'hAABB_CCDD, 4'b0101, 3, 1'b0, 32'h0, "strb.wr5"); idle(0);
    xfer(0, 1'b0, 32'h30, 32'h0, 4'hF, 3, 1'b0, 32'h11BB_33DD, "strb.rd5"); idle(0);
    xfer(0, 1'b1, 32'h30, 32'hFFFF_FFFF, 4'b0000, 3, 1'b0, 32'h0, "strb.wr0"); idle(0);
    xfer(0, 1'b0, 32'h30, 32'h0, 4'hF, 3, 1'b0, 32'h11BB_33DD, "strb.rd0"); idle(0);
`endif

    // Reset asserted inside a wait cycle, then held into what would be
    // the completing cycle: pready must stay low, write must be lost.
    @(posedge clk); #1;
    psel_v[0] = 1'b1; penable_v[0] = 1'b0; pwrite_v[0] = 1'b1;
    paddr_v[0] = 32'h10; pwdata_v[0] = 32'h0BAD_C0DE;
    @(posedge clk); #1; penable_v[0] = 1'b1;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst.wait.pready",  {63'd0, pready_v[0]},  64'd0);
    chk("rst.wait.pslverr", {63'd0, pslverr_v[0]}, 64'd0);
    @(posedge clk); #1;
    chk("rst.hold.pready", {63'd0, pready_v[0]}, 64'd0);
    psel_v[0] = 1'b0; penable_v[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 3, 1'b0, RV, "rst.rd10"); idle(0);
    xfer(0, 1'b0, 32'hFC, 32'h0, 4'hF, 3, 1'b0, RV, "rst.rdFC"); idle(0);
    xfer(1, 1'b0, 32'h8, 32'h0, 4'hF, 2, 1'b0, RV, "rst.ws0.rd8"); idle(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
